// File: rtl/enemy_scheduler_if.sv
// Handshake bundle between the enemy scheduler, the enemy datapaths and the
// VGA plot path. The scheduler uses the slave side and the environment
// (tick generator, datapath, adapter) uses the master side.
`timescale 1ns/1ps

interface enemy_scheduler_if #(
  parameter int SEL_W = 2
) ();
  logic             go;
  logic             frame_tick;
  logic [6:0]       enemy_y;
  logic [SEL_W-1:0] sel;
  logic             loadX;
  logic             loadY;
  logic             load_colour;
  logic             load_black;
  logic             en_counter;
  logic             plot;
  logic             busy;
  logic             enemy_passed;
  logic             frame_overrun;

  modport master (
    output go, frame_tick, enemy_y,
    input  sel, loadX, loadY, load_colour, load_black, en_counter, plot,
           busy, enemy_passed, frame_overrun
  );

  modport slave (
    input  go, frame_tick, enemy_y,
    output sel, loadX, loadY, load_colour, load_black, en_counter, plot,
           busy, enemy_passed, frame_overrun
  );
endinterface

// File: rtl/enemy_scheduler.sv
// Enemy scheduler: time-shares one 4x4 sprite plot path among NUM_ENEMIES
// enemy datapaths. First pass after go spawns and draws every enemy; each
// accepted frame tick then erases, moves (or respawns) and redraws each
// enemy in order 0..NUM_ENEMIES-1.
`timescale 1ns/1ps

module enemy_scheduler #(
  parameter int NUM_ENEMIES = 2,
  parameter int Y_LIMIT     = 116,
  parameter int SEL_W       = 2
) (
  input  logic               clock,
  input  logic               resetn,
  enemy_scheduler_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPAWN,
    S_DRAW,
    S_ERASE,
    S_MOVE,
    S_WAIT
  } state_e;

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_ENEMIES - 1);
  localparam logic [6:0]       Y_LIM    = 7'(Y_LIMIT);
  localparam logic [3:0]       PIX_LAST = 4'd15;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [3:0]       pix_q, pix_d;
  logic             init_pass_q, init_pass_d;
  logic             overrun_q, overrun_d;
  logic             at_limit;

  assign at_limit = (bus.enemy_y >= Y_LIM);

  // State, select, pixel counter and flags register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      sel_q       <= '0;
      pix_q       <= '0;
      init_pass_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q     <= state_d;
      sel_q       <= sel_d;
      pix_q       <= pix_d;
      init_pass_q <= init_pass_d;
      overrun_q   <= overrun_d;
    end
  end

  // Next-state logic: sprite sequencing, enemy select and overrun tracking.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // case statement leaves one unassigned (which would infer a latch).
    state_d     = state_q;
    sel_d       = sel_q;
    pix_d       = pix_q;
    init_pass_d = init_pass_q;
    overrun_d   = overrun_q;

    case (state_q)
      S_IDLE: begin
        if (bus.go) begin
          state_d     = S_SPAWN;
          sel_d       = '0;
          init_pass_d = 1'b1;
        end
      end
      S_SPAWN: begin
        state_d = S_DRAW;
        pix_d   = '0;
      end
      S_DRAW: begin
        pix_d = pix_q + 4'd1;
        if (pix_q == PIX_LAST) begin
          pix_d = '0;
          if (sel_q == LAST_SEL) begin
            sel_d   = '0;
            state_d = S_WAIT;
          end else begin
            sel_d   = sel_q + SEL_W'(1);
            state_d = init_pass_q ? S_SPAWN : S_ERASE;
          end
        end
      end
      S_ERASE: begin
        pix_d = pix_q + 4'd1;
        if (pix_q == PIX_LAST) begin
          pix_d   = '0;
          state_d = S_MOVE;
        end
      end
      S_MOVE: begin
        state_d = S_DRAW;
        pix_d   = '0;
      end
      S_WAIT: begin
        // Dropping go wins over a coincident tick.
        if (!bus.go) begin
          state_d = S_IDLE;
        end else if (bus.frame_tick) begin
          state_d     = S_ERASE;
          sel_d       = '0;
          pix_d       = '0;
          init_pass_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        sel_d   = '0;
        pix_d   = '0;
      end
    endcase

    // A tick while sprites are still being processed is lost; this includes
    // the last DRAW cycle, since the machine is not yet in WAIT then.
    if (bus.frame_tick && (state_q != S_IDLE) && (state_q != S_WAIT)) begin
      overrun_d = 1'b1;
    end
  end

  // Output decode from registered state; MOVE strobes also look at enemy_y.
  always_comb begin
    bus.loadX        = 1'b0;
    bus.loadY        = 1'b0;
    bus.load_colour  = 1'b0;
    bus.load_black   = 1'b0;
    bus.en_counter   = 1'b0;
    bus.plot         = 1'b0;
    bus.busy         = 1'b0;
    bus.enemy_passed = 1'b0;

    case (state_q)
      S_SPAWN: begin
        bus.busy        = 1'b1;
        bus.loadX       = 1'b1;
        bus.load_colour = 1'b1;
      end
      S_DRAW: begin
        bus.busy       = 1'b1;
        bus.en_counter = 1'b1;
        bus.plot       = 1'b1;
      end
      S_ERASE: begin
        bus.busy       = 1'b1;
        bus.en_counter = 1'b1;
        bus.plot       = 1'b1;
        bus.load_black = 1'b1;
      end
      S_MOVE: begin
        bus.busy = 1'b1;
        if (at_limit) begin
          bus.loadX        = 1'b1;
          bus.load_colour  = 1'b1;
          bus.enemy_passed = 1'b1;
        end else begin
          bus.loadY = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.sel           = sel_q;
  assign bus.frame_overrun = overrun_q;

endmodule

// File: tb/tb_enemy_scheduler.sv
// Self-checking bench for enemy_scheduler (NUM_ENEMIES=2). The reference
// model expands each accepted go / frame tick into the list of per-cycle
// sprite operations the frame must produce and pops one per clock.
`timescale 1ns/1ps

module tb_enemy_scheduler;

  localparam int NUM_ENEMIES = 2;
  localparam int Y_LIMIT     = 116;
  localparam int SEL_W       = 2;

  logic clk;
  logic rst_n;

  enemy_scheduler_if #(.SEL_W(SEL_W)) bus ();

  enemy_scheduler #(
    .NUM_ENEMIES (NUM_ENEMIES),
    .Y_LIMIT     (Y_LIMIT),
    .SEL_W       (SEL_W)
  ) dut (
    .clock  (clk),
    .resetn (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed vector layout:
  // [10:9] sel [8] loadX [7] loadY [6] load_colour [5] load_black
  // [4] en_counter [3] plot [2] busy [1] enemy_passed [0] frame_overrun
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [10:0] got, input logic [10:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [10:0] dut_vec();
    return {bus.sel, bus.loadX, bus.loadY, bus.load_colour, bus.load_black,
            bus.en_counter, bus.plot, bus.busy, bus.enemy_passed, bus.frame_overrun};
  endfunction

  function automatic logic [10:0] mkexp(input int sel, input bit lx, ly, lc, lb, en, pl, bs, ps, ov);
    return {2'(sel), lx, ly, lc, lb, en, pl, bs, ps, ov};
  endfunction

  // ---------------- reference model ----------------
  typedef enum {OP_SPAWN, OP_DRAW, OP_ERASE, OP_MOVE} op_e;
  typedef struct {
    op_e op;
    int  sel;
  } slot_t;

  slot_t sched[$];
  bit    m_running;
  bit    m_overrun;

  task automatic push_n(input op_e op, input int sel, input int n);
    slot_t s;
    s.op  = op;
    s.sel = sel;
    for (int k = 0; k < n; k++) sched.push_back(s);
  endtask

  task automatic model_reset();
    sched.delete();
    m_running = 0;
    m_overrun = 0;
  endtask

  function automatic logic [10:0] model_expect(input logic [6:0] y);
    logic [10:0] e;
    e    = '0;
    e[0] = m_overrun;
    if (sched.size() != 0) begin
      e[10:9] = 2'(sched[0].sel);
      e[2]    = 1'b1;
      case (sched[0].op)
        OP_SPAWN: begin e[8] = 1; e[6] = 1; end
        OP_DRAW:  begin e[4] = 1; e[3] = 1; end
        OP_ERASE: begin e[5] = 1; e[4] = 1; e[3] = 1; end
        OP_MOVE: begin
          if (int'(y) >= Y_LIMIT) begin e[8] = 1; e[6] = 1; e[1] = 1; end
          else e[7] = 1;
        end
        default: ;
      endcase
    end
    return e;
  endfunction

  task automatic model_advance(input bit g, input bit t);
    if (sched.size() != 0) begin
      void'(sched.pop_front());
      if (t) m_overrun = 1;
    end else if (!m_running) begin
      if (g) begin
        for (int e = 0; e < NUM_ENEMIES; e++) begin
          push_n(OP_SPAWN, e, 1);
          push_n(OP_DRAW, e, 16);
        end
        m_running = 1;
      end
    end else begin
      if (!g) m_running = 0;
      else if (t) begin
        for (int e = 0; e < NUM_ENEMIES; e++) begin
          push_n(OP_ERASE, e, 16);
          push_n(OP_MOVE, e, 1);
          push_n(OP_DRAW, e, 16);
        end
      end
    end
  endtask

  // One clock: drive at negedge, compare mid-cycle, advance the model.
  task automatic step(input bit g, input bit t, input logic [6:0] y);
    @(negedge clk);
    bus.go         = g;
    bus.frame_tick = t;
    bus.enemy_y    = y;
    #2;
    check("model", dut_vec(), model_expect(y));
    model_advance(g, t);
  endtask

  // Asynchronous reset asserted mid-cycle, released with go low.
  task automatic do_reset();
    @(negedge clk);
    #1;
    bus.go         = 1'b0;
    bus.frame_tick = 1'b0;
    rst_n          = 1'b0;
    #1;
    check("reset_async", dut_vec(), 11'b0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit          go;
    bit          tick;
    logic [6:0]  y;
    int          n;
    logic [10:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit t, input logic [6:0] y, input int n, input logic [10:0] exp);
    vec_t v;
    v.go   = 1'b1;
    v.tick = t;
    v.y    = y;
    v.n    = n;
    v.exp  = exp;
    tbl.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [10:0] z, spawn0, spawn1, draw0, draw1, erase0, erase1;
    logic [10:0] move_y0, move_y1, move_pass1;

    z          = '0;
    spawn0     = mkexp(0, 1, 0, 1, 0, 0, 0, 1, 0, 0);
    spawn1     = mkexp(1, 1, 0, 1, 0, 0, 0, 1, 0, 0);
    draw0      = mkexp(0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
    draw1      = mkexp(1, 0, 0, 0, 0, 1, 1, 1, 0, 0);
    erase0     = mkexp(0, 0, 0, 0, 1, 1, 1, 1, 0, 0);
    erase1     = mkexp(1, 0, 0, 0, 1, 1, 1, 1, 0, 0);
    move_y0    = mkexp(0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
    move_y1    = mkexp(1, 0, 1, 0, 0, 0, 0, 1, 0, 0);
    move_pass1 = mkexp(1, 1, 0, 1, 0, 0, 0, 1, 1, 0);

    // Initial pass, then two frames: one with a respawn, one at Y_LIMIT-1.
    add(0, 7'd40,  1, z);
    add(0, 7'd40,  1, spawn0);
    add(0, 7'd40, 16, draw0);
    add(0, 7'd40,  1, spawn1);
    add(0, 7'd40, 16, draw1);
    add(0, 7'd40,  3, z);
    add(1, 7'd40,  1, z);
    add(0, 7'd40, 16, erase0);
    add(0, 7'd40,  1, move_y0);
    add(0, 7'd40, 16, draw0);
    add(0, 7'd40, 16, erase1);
    add(0, 7'd116, 1, move_pass1);
    add(0, 7'd40, 16, draw1);
    add(0, 7'd40,  2, z);
    add(1, 7'd40,  1, z);
    add(0, 7'd40, 16, erase0);
    add(0, 7'd115, 1, move_y0);
    add(0, 7'd40, 16, draw0);
    add(0, 7'd40, 16, erase1);
    add(0, 7'd115, 1, move_y1);
    add(0, 7'd40, 16, draw1);
    add(0, 7'd40,  2, z);

    rst_n          = 1'b0;
    bus.go         = 1'b0;
    bus.frame_tick = 1'b0;
    bus.enemy_y    = 7'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    check("reset_state", dut_vec(), 11'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      for (int c = 0; c < tbl[i].n; c++) begin
        step(tbl[i].go, tbl[i].tick, tbl[i].y);
        check($sformatf("tbl%0d_c%0d", i, c), dut_vec(), tbl[i].exp);
      end
    end

    // Tick during a frame: flagged, sticky, frame still completes.
    step(1, 1, 7'd40);
    repeat (10) step(1, 0, 7'd40);
    step(1, 1, 7'd40);
    step(1, 0, 7'd40);
    check1("overrun_set", bus.frame_overrun, 1'b1);
    repeat (60) step(1, 0, 7'd40);
    check1("overrun_sticky", bus.frame_overrun, 1'b1);
    check1("frame_done_busy", bus.busy, 1'b0);

    // Next tick in WAIT accepted; reset lands at ERASE pix=7.
    step(1, 1, 7'd40);
    step(1, 0, 7'd40);
    check1("tick_accepted_black", bus.load_black, 1'b1);
    repeat (6) step(1, 0, 7'd40);
    @(negedge clk);
    #1;
    check1("plot_before_reset", bus.plot, 1'b1);
    do_reset();

    // Restart after reset.
    step(1, 0, 7'd40);
    step(1, 0, 7'd40);
    check1("restart_spawn", bus.loadX, 1'b1);
    repeat (40) step(1, 0, 7'd40);

    // go dropped mid-frame: frame completes, then IDLE.
    step(1, 1, 7'd40);
    repeat (80) step(0, 0, 7'd100);
    check1("go_drop_idle", bus.busy, 1'b0);

    // Tick coinciding with go=0 in WAIT is ignored.
    step(1, 0, 7'd40);
    repeat (40) step(1, 0, 7'd40);
    step(0, 1, 7'd40);
    step(0, 0, 7'd40);
    check1("tick_go0_no_erase", bus.load_black, 1'b0);
    repeat (3) step(0, 0, 7'd40);

    // Randomized traffic with boundary-biased enemy_y.
    for (int i = 0; i < 3000; i++) begin
      bit         g, t;
      logic [6:0] y;
      int         r;
      g = ($urandom_range(0, 99) < 97);
      t = ($urandom_range(0, 39) == 0);
      r = $urandom_range(0, 3);
      case (r)
        0: y = 7'd115;
        1: y = 7'd116;
        2: y = 7'd117;
        default: y = 7'($urandom_range(0, 127));
      endcase
      if (i == 1500) do_reset();
      step(g, t, y);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/enemy_scheduler.md
Name: enemy_scheduler

Overview:
- FSM that sequences the enemy datapath and shares its single pixel-plot path among NUM_ENEMIES enemy instances.
- Each frame, every enemy is handled in turn, in fixed order 0..NUM_ENEMIES-1:
  - erase its 4x4 sprite,
  - move it down one row, or respawn it at the top once it passes Y_LIMIT,
  - redraw it.
- Sits between the frame-tick generator and the enemy datapaths. Drives the datapath select and load strobes, and drives plot to the VGA adapter.

Parameters:
- NUM_ENEMIES, 2, number of enemy datapaths served; 1..4.
- Y_LIMIT, 116, enemy row at or beyond which the enemy respawns instead of moving.
- SEL_W, 2, width of the enemy select bus.

Ports:
- clock  in  1  system clock.
- resetn  in  1  asynchronous, active-low reset.
- go  in  1  game running; sampled only in IDLE and WAIT.
- frame_tick  in  1  one-cycle pulse, once per animation frame.
- enemy_y  in  7  yValue of the currently selected datapath (sprite top row).
- sel  out  SEL_W  index of the selected datapath; drives the datapath start input.
- loadX  out  1  respawn strobe: new X, Y cleared.
- loadY  out  1  move-down strobe.
- load_colour  out  1  latch new colour.
- load_black  out  1  force colour to 0 (erase).
- en_counter  out  1  advance the 4-bit pixel counter.
- plot  out  1  VGA write enable.
- busy  out  1  high in every state except IDLE and WAIT.
- enemy_passed  out  1  one-cycle pulse when an enemy respawns after reaching Y_LIMIT.
- frame_overrun  out  1  sticky flag; cleared only by reset.

Behaviour:
- States: IDLE, SPAWN, DRAW, ERASE, MOVE, WAIT.
- Internal 4-bit pix counter, cleared on entry to DRAW/ERASE, increments each cycle in those states. It stays lock-step with the datapath counter, which also wraps 15->0.
- Outputs are Moore, decoded from registered state. Exceptions: enemy_passed and the MOVE strobes, which also depend on enemy_y.
- Reset (asynchronous, any time including mid-sprite):
  - state=IDLE, sel=0, pix=0, frame_overrun=0.
  - All strobes, plot, busy and enemy_passed are 0 immediately; no partial-sprite cleanup.
- IDLE: all outputs 0. go=1 -> SPAWN with sel=0.
- SPAWN: 1 cycle; loadX=1, load_colour=1 -> DRAW.
- DRAW: 16 cycles; en_counter=1, plot=1, load_black=0. At pix==15:
  - if sel==NUM_ENEMIES-1: sel<=0, -> WAIT;
  - else sel<=sel+1, -> SPAWN during the initial pass (flag init_pass) or -> ERASE during normal frames.
- WAIT: all strobes 0.
  - frame_tick=1 and go=1 -> ERASE, sel=0, init_pass cleared.
  - go=0 -> IDLE; go=0 takes priority over frame_tick.
- ERASE: 16 cycles; en_counter=1, plot=1, load_black=1. At pix==15 -> MOVE.
- MOVE: 1 cycle, then -> DRAW.
  - If enemy_y >= Y_LIMIT: loadX=1, load_colour=1, enemy_passed=1.
  - Else: loadY=1.
- Cycle counts:
  - Initial pass: 17 cycles per enemy.
  - Normal frame: 33 cycles per enemy. With NUM_ENEMIES=2, WAIT is re-entered exactly 66 cycles after the tick is accepted.
- frame_tick in any state other than WAIT (or IDLE): the tick is dropped and frame_overrun<=1. A tick on the same cycle as the DRAW->WAIT transition is also dropped and flagged.
- sel changes only on a state transition; it is stable throughout each sprite.
- go=0 in the middle of a frame has no effect until WAIT.

Test Plan:
- Reset released, go=1 with NUM_ENEMIES=2 -> SPAWN(sel=0) 1 cycle, DRAW 16 cycles with plot=1, SPAWN(sel=1), DRAW 16, then WAIT at cycle 34 with busy=0.
- In WAIT, pulse frame_tick with enemy_y=40 -> ERASE 16 cycles (load_black=1, plot=1), MOVE with loadY=1 and loadX=0, DRAW 16 cycles; sequence repeats for sel=1; WAIT after 66 cycles.
- enemy_y=116 for sel=1 during MOVE -> loadX=1, load_colour=1, enemy_passed=1 for exactly 1 cycle, loadY=0; enemy_y=115 -> loadY=1, no pulse.
- frame_tick pulsed at cycle 10 of a frame -> frame_overrun=1 and stays 1; frame completes normally; the next tick in WAIT is accepted.
- Assert resetn=0 at ERASE pix=7 -> plot, en_counter, load_black and busy go 0 asynchronously; sel=0, state IDLE; after release with go=1 the sequence restarts at SPAWN.
- go dropped mid-frame -> frame completes, then WAIT->IDLE; a frame_tick coinciding with go=0 in WAIT is ignored (no ERASE).
